// File: rtl/loader_pkg.sv
// Shared FSM encoding, stream framing constants and length validation for the program loader.
// The CHECK state is only reachable when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LEN_LO = 3'd1;
    localparam state_t S_LEN_HI = 3'd2;
    localparam state_t S_DATA   = 3'd3;
    localparam state_t S_WRITE  = 3'd4;
    localparam state_t S_DONE   = 3'd5;
    localparam state_t S_CHECK  = 3'd6;

    // A length is unusable if empty or larger than the addressable instruction memory.
    function automatic logic len_bad(input logic [15:0] n, input int addr_bits);
        return (n == 16'd0) || ({16'd0, n} > (32'd1 << addr_bits));
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream receive port and instruction-memory write port of the program loader.
interface program_loader_if #(
    parameter int ADDR_BITS = 8
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [31:0]          mem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs bytes little-endian into a 32-bit word; word_valid pulses one cycle after the last byte.
// Advances only on byte_vld, so gaps of any length leave the partial word untouched.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [7:0]  byte_dat,
    input  logic        byte_vld,
    output logic        last_byte,
    output logic [31:0] word,
    output logic        word_valid
);
    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt;

    assign last_byte = (cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_vld) begin
                // Shift in from the top so the first byte ends up in bits 7:0.
                word <= {byte_dat, word[31:8]};
                cnt  <= cnt + 1'b1;
                if (last_byte) begin
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory while holding the core.
// One write cycle per word with rx_ready low; LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    program_loader_if.master bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);
    localparam int IDX_W = ADDR_BITS + 1;
    localparam int LEN_W = LEN_BYTES * 8;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_full;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic             xfer;
    logic             data_vld;
    logic             session_start;
    logic             last_byte;
    logic             last_word;
    logic             word_valid;
    logic [31:0]      word;

    assign xfer          = bus.rx_valid && bus.rx_ready;
    assign data_vld      = xfer && (state == S_DATA);
    assign session_start = start && ((state == S_IDLE) || (state == S_DONE));
    assign len_full      = {bus.rx_data, len[7:0]};
    assign idx_inc       = idx + 1'b1;
    assign last_word     = (32'(idx_inc) == 32'(len));

    word_assembler u_asm (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (session_start),
        .byte_dat   (bus.rx_data),
        .byte_vld   (data_vld),
        .last_byte  (last_byte),
        .word       (word),
        .word_valid (word_valid)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (!reset_n || session_start) begin
            csum <= '0;
        end else if (data_vld) begin
            csum <= csum ^ bus.rx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            len   <= '0;
            idx   <= '0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_LEN_LO;
                        len   <= '0;
                        idx   <= '0;
                        done  <= 1'b0;
                        error <= 1'b0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= bus.rx_data;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= bus.rx_data;
                        if (len_bad(len_full, ADDR_BITS)) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (data_vld && last_byte) begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    idx <= idx_inc;
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= S_CHECK;
`else
                        done  <= 1'b1;
                        state <= S_DONE;
`endif
                    end else begin
                        state <= S_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        done  <= 1'b1;
                        error <= (bus.rx_data != csum);
                        state <= S_DONE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rx_ready = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA: bus.rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK:                    bus.rx_ready = 1'b1;
`endif
            default:                    bus.rx_ready = 1'b0;
        endcase
    end

    assign cpu_hold      = (state != S_IDLE) && (state != S_DONE);
    assign bus.mem_we    = (state == S_WRITE) && word_valid;
    assign bus.mem_addr  = idx[ADDR_BITS-1:0];
    assign bus.mem_wdata = word;

endmodule
